// File: rtl/dcc_switch_sequencer_if.sv
// Request channel for the DCC/DCS switch sequencer.
//
// Handshake: a request transfers on a clk cycle where valid and ready are
// both high. The requester holds valid, idx and park stable until that
// cycle. ready never depends combinationally on valid, and valid may be
// held high across a busy sequence. The request is then taken on the first
// cycle that ready is high again.
//
// Signals
//   valid  requester -> sequencer  request present
//   ready  sequencer -> requester  sequencer is idle and can take a request
//   idx    requester -> sequencer  target clock source index
//   park   requester -> sequencer  1 = switch every source off, idx ignored
interface dcc_switch_sequencer_if #(
  parameter int IDX_W = 2
);
  logic             valid;
  logic             ready;
  logic [IDX_W-1:0] idx;
  logic             park;

  modport master (output valid, output idx, output park, input ready);
  modport slave  (input valid, input idx, input park, output ready);
endinterface

// File: rtl/dcc_switch_sequencer.sv
// Glitch-free clock-source switch controller for a bank of N_CLK DCC clock
// gates feeding one DCS mux. Every change is break-before-make:
//   1. all DCCs off
//   2. drain for OFF_CYC cycles
//   3. move the DCS select
//   4. settle for SETTLE_CYC cycles
//   5. enable the new DCC
// The block runs on a free-running control clock that is independent of
// the gated clocks.
//
// Ports
//   clk         free-running control clock
//   rst_n       asynchronous active-low reset
//   req         request channel (slave side): valid/ready/idx/park
//   dcc_en      DCC enables, zero- or one-hot
//   dcs_sel     DCS select
//   active_vld  a source is currently enabled
//   active_idx  index of the enabled source (meaningful when active_vld=1)
//   busy        a sequence is in progress (state != IDLE)
//   done        one-cycle pulse when a request completes
//   err         one-cycle pulse when a request is rejected
//   state_dbg   current FSM state encoding, for observation only
//
// All outputs are registered. They are computed from the next-state logic,
// so a value appears in the same cycle as the state that produces it.
module dcc_switch_sequencer #(
  parameter int N_CLK      = 4,
  parameter int IDX_W      = 2,
  parameter int OFF_CYC    = 8,
  parameter int SETTLE_CYC = 16,
  parameter int RESET_IDX  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dcc_switch_sequencer_if.slave req,
  output logic [N_CLK-1:0]     dcc_en,
  output logic [IDX_W-1:0]     dcs_sel,
  output logic                 active_vld,
  output logic [IDX_W-1:0]     active_idx,
  output logic                 busy,
  output logic                 done,
  err,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    ENABLE = 3'd4
  } state_t;

  localparam logic [7:0]       OFF_LAST    = 8'(OFF_CYC - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] RST_IDX     = IDX_W'(RESET_IDX);
  localparam logic [IDX_W:0]   N_CLK_W     = (IDX_W + 1)'(N_CLK);
  localparam logic [N_CLK-1:0] ONE_HOT0    = N_CLK'(1);

  state_t           state_q, state_n;
  logic [7:0]       cnt_q, cnt_n;
  logic [IDX_W-1:0] tgt_q, tgt_n;
  logic             park_q, park_n;
  logic [N_CLK-1:0] dcc_en_n;
  logic [IDX_W-1:0] dcs_sel_n;
  logic             active_vld_n;
  logic [IDX_W-1:0] active_idx_n;
  logic             ready_q;
  logic             done_n, err_n;
  logic             accept;

  // ready is registered and high exactly in IDLE, so this is the transfer.
  assign accept    = req.valid & ready_q;
  assign req.ready = ready_q;
  assign state_dbg = state_q;

  // The counter counts up from 0 on entry to DRAIN or SETTLE. The state
  // advances on the cycle it reaches the last count, so each hold state
  // lasts exactly OFF_CYC or SETTLE_CYC cycles. Reset places the FSM at
  // the first SETTLE cycle, so the boot sequence gets the full settle time.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    tgt_n        = tgt_q;
    park_n       = park_q;
    dcc_en_n     = dcc_en;
    dcs_sel_n    = dcs_sel;
    active_vld_n = active_vld;
    active_idx_n = active_idx;
    done_n       = 1'b0;
    err_n        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!req.park && ({1'b0, req.idx} >= N_CLK_W)) begin
            err_n = 1'b1;
          end else if (!req.park && active_vld && (req.idx == active_idx)) begin
            // Already running from the requested source.
            done_n = 1'b1;
          end else if (req.park && !active_vld) begin
            // Already parked.
            done_n = 1'b1;
          end else begin
            tgt_n        = req.idx;
            park_n       = req.park;
            cnt_n        = 8'd0;
            dcc_en_n     = '0;
            active_vld_n = 1'b0;
            state_n      = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (cnt_q == OFF_LAST) begin
          if (park_q) begin
            // The DCS select is left where it was.
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            dcs_sel_n = tgt_q;
            state_n   = SWITCH;
          end
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end

      SWITCH: begin
        cnt_n   = 8'd0;
        state_n = SETTLE;
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          dcc_en_n     = ONE_HOT0 << tgt_q;
          active_vld_n = 1'b1;
          active_idx_n = tgt_q;
          done_n       = 1'b1;
          state_n      = ENABLE;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end

      ENABLE: begin
        state_n = IDLE;
      end

      default: begin
        // An unreachable encoding gates everything off and reboots.
        dcc_en_n     = '0;
        active_vld_n = 1'b0;
        tgt_n        = RST_IDX;
        park_n       = 1'b0;
        cnt_n        = 8'd0;
        state_n      = SETTLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SETTLE;
      cnt_q      <= 8'd0;
      tgt_q      <= RST_IDX;
      park_q     <= 1'b0;
      dcc_en     <= '0;
      dcs_sel    <= RST_IDX;
      active_vld <= 1'b0;
      active_idx <= RST_IDX;
      busy       <= 1'b1;
      ready_q    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      tgt_q      <= tgt_n;
      park_q     <= park_n;
      dcc_en     <= dcc_en_n;
      dcs_sel    <= dcs_sel_n;
      active_vld <= active_vld_n;
      active_idx <= active_idx_n;
      busy       <= (state_n != IDLE);
      ready_q    <= (state_n == IDLE);
      done       <= done_n;
      err        <= err_n;
    end
  end

endmodule
